axis_h2c_rx: RTL and testbench

AXIS_H2C_RX -- requirements
Module: axis_h2c_rx

---
 rtl/proc_pipe_pckg.sv | 13 +
 rtl/sync_fifo_fwft.sv | 45 ++++
 rtl/axis_h2c_rx.sv | 116 +++++++++++
 tb/tb_axis_h2c_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pipe_pckg.sv
// rtl/proc_pipe_pckg.sv - shared types and defaults for the processing pipeline
package proc_pipe_pckg;

  localparam int C_AXIS_DATA_WDT_DFLT = 64;
  localparam int C_LEN_WDT_DFLT       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2
  } h2c_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - single-clock first-word-fall-through FIFO
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full from empty when the indices match
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/axis_h2c_rx.sv
// rtl/axis_h2c_rx.sv - host-to-card stream receiver with length check and FWFT buffer
module axis_h2c_rx
  import proc_pipe_pckg::*;
#(
  parameter int C_AXIS_DATA_WDT = C_AXIS_DATA_WDT_DFLT,
  parameter int C_FIFO_DEPTH    = 16,
  parameter int C_LEN_WDT       = C_LEN_WDT_DFLT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [C_AXIS_DATA_WDT-1:0]   s_axis_tdata,
  input  logic [C_AXIS_DATA_WDT/8-1:0] s_axis_tkeep,
  input  logic                         s_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         start,
  input  logic [C_LEN_WDT-1:0]         len_beats,
  output logic [C_AXIS_DATA_WDT-1:0]   m_data,
  output logic                         m_last,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         err_early_last,
  output logic                         err_missing_last,
  output logic                         err_keep,
  output logic [C_LEN_WDT-1:0]         beat_cnt
);

  h2c_state_e                 state_q;
  h2c_state_e                 state_d;
  logic                       done_d;
  logic [C_LEN_WDT-1:0]       len_q;
  logic [C_LEN_WDT-1:0]       cnt_inc;
  logic                       accept;
  logic                       hit_len;
  logic                       last_beat;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [C_AXIS_DATA_WDT:0]   fifo_rd;

  assign s_axis_tready = (state_q == RECV) && !fifo_full;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign cnt_inc       = beat_cnt + 1'b1;
  assign hit_len       = (cnt_inc == len_q);
  // Either the length count or an early tlast closes the transfer
  assign last_beat     = hit_len || s_axis_tlast;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len_beats != '0)) state_d = RECV;
        else if (start)                 done_d  = 1'b1;
      end
      RECV: begin
        if (accept && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      done             <= 1'b0;
      len_q            <= '0;
      beat_cnt         <= '0;
      err_early_last   <= 1'b0;
      err_missing_last <= 1'b0;
      err_keep         <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      if (state_q == IDLE && start) begin
        beat_cnt         <= '0;
        err_early_last   <= 1'b0;
        err_missing_last <= 1'b0;
        err_keep         <= 1'b0;
        if (len_beats != '0) len_q <= len_beats;
      end else if (accept) begin
        beat_cnt <= cnt_inc;
        if (s_axis_tlast && !hit_len)         err_early_last   <= 1'b1;
        if (hit_len && !s_axis_tlast)         err_missing_last <= 1'b1;
        if (!last_beat && s_axis_tkeep != '1) err_keep         <= 1'b1;
      end
    end
  end

  sync_fifo_fwft #(
    .WIDTH (C_AXIS_DATA_WDT + 1),
    .DEPTH (C_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_data ({last_beat, s_axis_tdata}),
    .full    (fifo_full),
    .rd_en   (m_ready),
    .rd_data (fifo_rd),
    .empty   (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign m_last  = fifo_rd[C_AXIS_DATA_WDT];
  assign m_data  = fifo_rd[C_AXIS_DATA_WDT-1:0];

endmodule

// File: tb/tb_axis_h2c_rx.sv
// tb/tb_axis_h2c_rx.sv - directed and randomized bench for axis_h2c_rx
module tb_axis_h2c_rx;

  localparam int DW    = 64;
  localparam int LW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic [7:0]    s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          start;
  logic [LW-1:0] len_beats;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic          done;
  logic          err_early_last;
  logic          err_missing_last;
  logic          err_keep;
  logic [LW-1:0] beat_cnt;

  int checks   = 0;
  int failures = 0;
  logic [63:0] dat [64];

  axis_h2c_rx #(
    .C_AXIS_DATA_WDT (DW),
    .C_FIFO_DEPTH    (DEPTH),
    .C_LEN_WDT       (LW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tkeep     (s_axis_tkeep),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .start            (start),
    .len_beats        (len_beats),
    .m_data           (m_data),
    .m_last           (m_last),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .busy             (busy),
    .done             (done),
    .err_early_last   (err_early_last),
    .err_missing_last (err_missing_last),
    .err_keep         (err_keep),
    .beat_cnt         (beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outcome is derived from the length/tlast rules, not from DUT state
  task automatic run_xfer(input int L, input int T, input int kbad, input int hold,
                          input bit rnd, input bit restart);
    int n, acc, popped, dones;
    bit fin, exp_early, exp_miss, exp_keep;
    n         = (T > 0 && T < L) ? T : L;
    exp_early = (T > 0 && T < L);
    exp_miss  = (T == 0) || (T > L);
    exp_keep  = (kbad > 0) && (kbad < n);
    for (int i = 0; i < 64; i++) dat[i] = {$urandom, $urandom};
    s_axis_tvalid = 1'b0;
    start = 1'b1;
    len_beats = L;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    acc = 0; popped = 0; dones = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      s_axis_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_tdata  = dat[acc & 63];
      s_axis_tkeep  = (acc + 1 == kbad) ? 8'h0f : 8'hff;
      s_axis_tlast  = (acc + 1 == T);
      if (hold > 0 && cyc < hold) m_ready = 1'b0;
      else m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (restart && cyc == 2) begin
        start = 1'b1;
        len_beats = 2;
      end else start = 1'b0;
      #1;
      if (hold > 0 && cyc == hold) begin
        chk("accepted_while_stalled", acc, (n < DEPTH) ? n : DEPTH);
        chk("tready_when_full", s_axis_tready, 0);
      end
      if (acc == n) chk("tready_after_final", s_axis_tready, 0);
      if (m_valid && m_ready) begin
        chk("m_data", m_data, dat[popped & 63]);
        chk("m_last", m_last, (popped + 1 == n));
        popped++;
      end
      if (s_axis_tvalid && s_axis_tready) acc++;
      step();
      if (done) begin
        dones++;
        fin = 1'b1;
        chk("popped_at_done", popped, n);
        chk("busy_at_done", busy, 0);
      end
    end
    start = 1'b0;
    chk("done_seen", fin, 1);
    chk("accepted_beats", acc, n);
    chk("beat_cnt", beat_cnt, n);
    chk("err_early_last", err_early_last, exp_early);
    chk("err_missing_last", err_missing_last, exp_miss);
    chk("err_keep", err_keep, exp_keep);
    s_axis_tvalid = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (done) dones++;
      chk("idle_tready", s_axis_tready, 0);
      chk("idle_m_valid", m_valid, 0);
    end
    s_axis_tvalid = 1'b0;
    chk("done_once", dones, 1);
    chk("beat_cnt_hold", beat_cnt, n);
  endtask

  initial begin
    int L, T, kb, n;
    rst_n = 1'b0;
    start = 1'b0;
    len_beats = '0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b0;
    m_ready = 1'b0;
    repeat (3) step();
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_errs", {err_early_last, err_missing_last, err_keep}, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    rst_n = 1'b1;
    step();

    run_xfer(4, 4, 0, 0, 1'b0, 1'b0);
    run_xfer(8, 3, 0, 0, 1'b0, 1'b0);
    run_xfer(2, 0, 0, 0, 1'b0, 1'b0);
    run_xfer(40, 40, 0, 30, 1'b0, 1'b0);
    run_xfer(6, 6, 3, 0, 1'b1, 1'b1);

    start = 1'b1;
    len_beats = 0;
    step();
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_tready", s_axis_tready, 0);
    chk("len0_errs", {err_early_last, err_missing_last, err_keep}, 0);
    step();
    chk("len0_done_pulse", done, 0);
    chk("len0_busy_after", busy, 0);

    start = 1'b1;
    len_beats = 10;
    step();
    start = 1'b0;
    m_ready = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tkeep = 8'hff;
    s_axis_tlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_axis_tdata = {$urandom, $urandom};
      step();
    end
    chk("pre_rst_beat_cnt", beat_cnt, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tready", s_axis_tready, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_errs", {err_early_last, err_missing_last, err_keep}, 0);
    chk("mid_rst_beat_cnt", beat_cnt, 0);
    step();
    rst_n = 1'b1;
    s_axis_tvalid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_done", done, 0);
      chk("post_rst_m_valid", m_valid, 0);
    end
    run_xfer(3, 3, 0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      L  = $urandom_range(1, 24);
      T  = $urandom_range(0, L + 2);
      n  = (T > 0 && T < L) ? T : L;
      kb = $urandom_range(0, L);
      if (kb == n) kb = 0;
      run_xfer(L, T, kb, 0, 1'b1, r[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
